// File: rtl/regfile_snapshot_engine.sv
// Bulk save/restore engine for the integer register file: SAVE streams x0..x(N-1)
// out through one read port, RESTORE writes x1..x(N-1) from an input stream.
module regfile_snapshot_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_restore,
  output logic                  cmd_ready,
  input  logic                  cmd_abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [1:0]            dbg_state
);

  // Handshakes: a beat/command transfers in a cycle where valid && ready are both
  // high at the rising edge; the producer holds its payload stable until then.

  localparam int N     = 2 ** ADDR_WIDTH;
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic                    out_last_q, out_last_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    save_load;

  assign cmd_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign in_ready        = (state_q == ST_RESTORE) && !cmd_abort;
  assign rf_read_addr    = (state_q == ST_SAVE) ? idx_q[ADDR_WIDTH-1:0] : '0;
  assign done            = done_q;
  assign rf_write_enable = wr_en_q;
  assign rf_write_addr   = wr_addr_q;
  assign rf_write_data   = wr_data_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_addr        = out_addr_q;
  assign out_last        = out_last_q;
  assign dbg_state       = state_q;

  // The output skid is one register deep, so a new read may land only when it is empty or draining.
  assign save_load = (!out_valid_q || out_ready) && (idx_q <= IDX_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_restore ? ST_RESTORE : ST_SAVE;
          idx_d   = cmd_restore ? IDX_ONE : '0;
        end
      end
      ST_SAVE: begin
        if (cmd_abort) begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          out_valid_d = 1'b0;
        end else begin
          if (save_load) begin
            out_data_d  = rf_read_data;
            out_addr_d  = idx_q[ADDR_WIDTH-1:0];
            out_last_d  = (idx_q == IDX_LAST);
            out_valid_d = 1'b1;
            idx_d       = idx_q + IDX_ONE;
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
          if (out_valid_q && out_ready && out_last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RESTORE: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_WIDTH-1:0];
          wr_data_d = in_data;
          idx_d     = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

endmodule
